// File: rtl/ap_ctrl_drv_pkg.sv
// Shared types for the ap_ctrl_hs initiator: FSM state encoding and the cycle-stamp type.
package ap_ctrl_drv_pkg;
    localparam int CYC_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} drv_state_t;
    typedef logic [CYC_W_DEF-1:0] stamp_t;
endpackage

// File: rtl/ap_lat_fifo.sv
// Start-time stamps of in-flight transactions, oldest at the head.
// The caller never pops when empty or pushes when full, so no flags are kept.
module ap_lat_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (pop_i)  rd_q <= nxt(rd_q);
        end
    end

    assign head_o = mem_q[rd_q];
endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: issues a commanded number of starts with bounded
// outstanding work, measures start->done latency and aborts on stalls.
module ap_ctrl_hs_driver
    import ap_ctrl_drv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int CYC_W       = 32,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_abort,
    output logic             core_ap_start,
    input  logic             core_ap_ready,
    input  logic             core_ap_done,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_timeout,
    output logic             stat_proto_err,
    output logic [CNT_W-1:0] stat_started,
    output logic [CNT_W-1:0] stat_completed,
    output logic [CYC_W-1:0] stat_last_lat,
    output logic [CYC_W-1:0] stat_max_lat,
    output logic [CYC_W-1:0] stat_run_cycles
);
    localparam int               OUT_W     = $clog2(MAX_OUT) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    drv_state_t       state_q;
    logic             cmd_ready_q, start_q, abort_q, done_q, to_q, perr_q;
    logic [CNT_W-1:0] count_q, started_q, completed_q;
    logic [OUT_W-1:0] out_q;
    logic [CYC_W-1:0] stamp_q, last_lat_q, max_lat_q, run_q;
    logic [31:0]      stall_q;

    logic             hs, pop, perr, progress, pending, abort_d, more, to_hit;
    logic [CNT_W-1:0] started_d;
    logic [OUT_W-1:0] out_d;
    logic [CYC_W-1:0] head, lat;

    assign hs        = start_q & core_ap_ready;
    assign pop       = core_ap_done & (out_q != '0);
    assign perr      = core_ap_done & (out_q == '0);
    assign progress  = hs | core_ap_done;
    assign pending   = start_q & ~core_ap_ready;
    assign started_d = started_q + CNT_W'(hs);
    assign out_d     = out_q + OUT_W'(hs) - OUT_W'(pop);
    assign abort_d   = abort_q | cmd_abort;
    assign more      = (started_d < count_q) & (out_d < MAX_OUT_V) & ~abort_d;
    assign lat       = stamp_q - head;
    assign to_hit    = (TIMEOUT_CYC != 0) && (state_q != IDLE) && !progress
                       && (stall_q + 32'd1 == 32'(TIMEOUT_CYC));

    ap_lat_fifo #(.DEPTH(MAX_OUT), .W(CYC_W)) u_fifo (
        .clk_i   (ap_clk),
        .rst_n_i (ap_rst_n),
        .flush_i (to_hit),
        .push_i  (hs),
        .pop_i   (pop),
        .din_i   (stamp_q),
        .head_o  (head)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            to_q        <= 1'b0;
            perr_q      <= 1'b0;
            count_q     <= '0;
            started_q   <= '0;
            completed_q <= '0;
            out_q       <= '0;
            stamp_q     <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            run_q       <= '0;
            stall_q     <= '0;
        end else begin
            stamp_q     <= stamp_q + CYC_W'(1);
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            to_q        <= 1'b0;
            perr_q      <= perr;
            out_q       <= out_d;
            started_q   <= started_d;
            if (pop) begin
                completed_q <= completed_q + CNT_W'(1);
                last_lat_q  <= lat;
                if (lat > max_lat_q) max_lat_q <= lat;
            end
            if (progress)
                stall_q <= '0;
            else if (state_q != IDLE && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (state_q != IDLE && run_q != '1)
                run_q <= run_q + CYC_W'(1);

            case (state_q)
                IDLE: begin
                    abort_q     <= 1'b0;
                    cmd_ready_q <= ~(cmd_valid & cmd_ready_q & (cmd_count != '0));
                    if (cmd_valid && cmd_ready_q) begin
                        started_q   <= '0;
                        completed_q <= '0;
                        last_lat_q  <= '0;
                        max_lat_q   <= '0;
                        stall_q     <= '0;
                        if (cmd_count == '0) begin
                            run_q  <= CYC_W'(1);
                            done_q <= 1'b1;
                        end else begin
                            run_q   <= '0;
                            count_q <= cmd_count;
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    abort_q <= abort_d;
                    // An unacknowledged start is never retracted, not even by abort.
                    start_q <= pending | more;
                    if (started_d == count_q || (abort_d && !pending))
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    abort_q <= abort_d;
                    if (out_q == '0) begin
                        state_q     <= IDLE;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (to_hit) begin
                state_q     <= IDLE;
                start_q     <= 1'b0;
                out_q       <= '0;
                to_q        <= 1'b1;
                done_q      <= 1'b1;
                cmd_ready_q <= 1'b1;
            end
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign core_ap_start   = start_q;
    assign stat_busy       = (state_q != IDLE);
    assign stat_done       = done_q;
    assign stat_timeout    = to_q;
    assign stat_proto_err  = perr_q;
    assign stat_started    = started_q;
    assign stat_completed  = completed_q;
    assign stat_last_lat   = last_lat_q;
    assign stat_max_lat    = max_lat_q;
    assign stat_run_cycles = run_q;
endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed and randomized runs of the ap_ctrl_hs initiator against a
// transaction-level model (queue of start times, counters, stall count).
module tb_ap_ctrl_hs_driver;
    localparam int MO = 2;
    localparam int TO = 16;

    logic        ap_clk = 1'b0, ap_rst_n = 1'b0, cmd_valid = 1'b0, cmd_abort = 1'b0;
    logic        core_ap_ready = 1'b0, core_ap_done = 1'b0;
    logic [15:0] cmd_count = '0;
    logic        cmd_ready, core_ap_start, stat_busy, stat_done, stat_timeout, stat_proto_err;
    logic [15:0] stat_started, stat_completed;
    logic [31:0] stat_last_lat, stat_max_lat, stat_run_cycles;

    ap_ctrl_hs_driver #(.CNT_W(16), .CYC_W(32), .MAX_OUT(MO), .TIMEOUT_CYC(TO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_count(cmd_count), .cmd_abort(cmd_abort), .core_ap_start(core_ap_start),
        .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done), .stat_busy(stat_busy),
        .stat_done(stat_done), .stat_timeout(stat_timeout), .stat_proto_err(stat_proto_err),
        .stat_started(stat_started), .stat_completed(stat_completed),
        .stat_last_lat(stat_last_lat), .stat_max_lat(stat_max_lat),
        .stat_run_cycles(stat_run_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    // core responder knobs
    int rdy_mode = 0, lat_lo = 1, lat_hi = 1, dn_budget = -1;
    bit force_done = 0, sched_dn = 0;
    // reference model
    int q[$], dq[$];
    bit m_active = 0, m_abort = 0, m_pend = 0, m_rst = 0, acc_flag = 0;
    int m_count = 0, m_started = 0, m_comp = 0, m_last = 0, m_max = 0, m_run = 0, m_stall = 0;
    int acc_cyc = 0, to_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        case (rdy_mode)
            0:       core_ap_ready = 1'b0;
            1:       core_ap_ready = 1'b1;
            default: core_ap_ready = 1'($urandom_range(0, 1));
        endcase
        sched_dn     = (dn_budget != 0) && (dq.size() > 0) && (dq[0] <= cyc + 1);
        core_ap_done = sched_dn || force_done;
    endtask

    task automatic tick();
        bit hs, dn, acc, exp_pe, exp_to, exp_zd, ok_done, exp_start;
        int e, due;
        drive();
        hs = core_ap_start && core_ap_ready;
        dn = core_ap_done;
        acc = cmd_valid && cmd_ready;
        e = cyc + 1;
        exp_pe = 0; exp_to = 0; exp_zd = 0; acc_flag = 0;
        if (!ap_rst_n) begin
            q.delete(); dq.delete();
            m_active = 0; m_abort = 0; m_pend = 0; m_rst = 1; m_count = 0;
            m_started = 0; m_comp = 0; m_last = 0; m_max = 0; m_run = 0; m_stall = 0;
        end else begin
            m_rst = 0;
            if (m_active) m_run++;
            if (m_active && cmd_abort) m_abort = 1;
            if (dn) begin
                if (q.size() == 0) exp_pe = 1;
                else begin
                    m_last = e - q.pop_front();
                    m_comp++;
                    if (m_last > m_max) m_max = m_last;
                end
                if (sched_dn) begin
                    void'(dq.pop_front());
                    if (dn_budget > 0) dn_budget--;
                end
            end
            if (hs) begin
                q.push_back(e);
                m_started++;
                due = e + $urandom_range(lat_lo, lat_hi);
                if (dq.size() > 0 && due <= dq[$]) due = dq[$] + 1;
                dq.push_back(due);
            end
            if (hs || dn) m_stall = 0;
            else if (m_active) m_stall++;
            if (m_active && m_stall == TO) begin
                exp_to = 1; m_active = 0; m_pend = 0; q.delete(); dq.delete();
            end else
                m_pend = m_active && core_ap_start && !core_ap_ready;
            if (acc) begin
                acc_flag = 1;
                m_started = 0; m_comp = 0; m_last = 0; m_max = 0; m_run = 0;
                m_abort = 0; m_stall = 0;
                if (cmd_count == 0) begin exp_zd = 1; m_run = 1; end
                else begin m_active = 1; m_count = int'(cmd_count); end
            end
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        cyc++;
        force_done = 0;
        if (acc_flag) acc_cyc = cyc;
        if (exp_to) to_cyc = cyc;

        ok_done = m_active && q.size() == 0 && !m_pend && (m_started == m_count || m_abort);
        if (exp_to || exp_zd || !ok_done)
            chk("done_pulse", stat_done, exp_to || exp_zd);
        if (exp_to || exp_zd || (ok_done && stat_done === 1'b1)) begin
            chk("run_cycles", stat_run_cycles, m_run);
            m_active = 0;
        end
        exp_start = m_active && (m_pend || (m_started < m_count && q.size() < MO && !m_abort));
        chk("start", core_ap_start, exp_start);
        chk("cmd_ready", cmd_ready, !m_active && !m_rst);
        chk("busy", stat_busy, m_active);
        chk("timeout", stat_timeout, exp_to);
        chk("proto_err", stat_proto_err, exp_pe);
        chk("started", stat_started, m_started);
        chk("completed", stat_completed, m_comp);
        chk("last_lat", stat_last_lat, m_last);
        chk("max_lat", stat_max_lat, m_max);
    endtask

    task automatic start_run(input int cnt);
        cmd_valid = 1'b1;
        cmd_count = 16'(cnt);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (acc_flag) break;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", acc_cyc, cyc);
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && m_active; k++) tick();
        chk("run_ends_in_bound", m_active, 0);
    endtask

    initial begin
        // reset
        repeat (3) tick();
        chk("rst_started", stat_started, 0);
        chk("rst_ready_low", cmd_ready, 0);
        ap_rst_n = 1'b1;
        tick();
        chk("rst_ready_high", cmd_ready, 1);

        // T1: ready with start, done 5 cycles after each handshake
        rdy_mode = 1; lat_lo = 5; lat_hi = 5; dn_budget = -1;
        start_run(3);
        wait_idle(100);
        chk("t1_started", stat_started, 3);
        chk("t1_completed", stat_completed, 3);
        chk("t1_last_lat", stat_last_lat, 5);
        chk("t1_max_lat", stat_max_lat, 5);
        tick();

        // T2: done withheld, start limited by outstanding cap
        dn_budget = 0;
        start_run(4);
        repeat (6) tick();
        chk("t2_started_cap", stat_started, 2);
        chk("t2_start_low", core_ap_start, 0);
        dn_budget = 1;
        tick();
        chk("t2_start_back", core_ap_start, 1);
        dn_budget = -1;
        wait_idle(100);
        chk("t2_completed", stat_completed, 4);

        // T3: abort while start is high and ready is low
        dn_budget = 0;
        start_run(10);
        for (int k = 0; k < 10 && m_started < 2; k++) tick();
        rdy_mode = 0; dn_budget = 1;
        for (int k = 0; k < 20 && core_ap_start !== 1'b1; k++) tick();
        chk("t3_start_again", core_ap_start, 1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
        chk("t3_start_held", core_ap_start, 1);
        chk("t3_started_2", stat_started, 2);
        rdy_mode = 1;
        tick();
        chk("t3_started_3", stat_started, 3);
        chk("t3_start_drop", core_ap_start, 0);
        dn_budget = -1;
        wait_idle(100);
        chk("t3_completed", stat_completed, 3);

        // T4: core never ready -> stall timeout
        rdy_mode = 0;
        start_run(3);
        wait_idle(40);
        chk("t4_timeout_cycle", to_cyc - acc_cyc, TO);
        chk("t4_start_off", core_ap_start, 0);
        chk("t4_busy_off", stat_busy, 0);

        // T5: handshake and done together, stray done, zero-count run
        rdy_mode = 1; lat_lo = 1; lat_hi = 1;
        start_run(4);
        wait_idle(50);
        chk("t5_completed", stat_completed, 4);
        chk("t5_max_lat", stat_max_lat, 1);
        force_done = 1;
        tick();
        chk("t5_proto_err", stat_proto_err, 1);
        chk("t5_counters_kept", stat_completed, 4);
        start_run(0);
        chk("t5_zero_done", stat_done, 1);
        chk("t5_zero_started", stat_started, 0);
        tick();

        // T6: reset in the middle of a run
        lat_lo = 5; lat_hi = 5;
        start_run(8);
        repeat (3) tick();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        chk("t6_start_off", core_ap_start, 0);
        chk("t6_started_0", stat_started, 0);
        tick();
        start_run(2);
        wait_idle(100);
        chk("t6_rerun", stat_completed, 2);

        // randomized runs, odd ones with sporadic aborts
        for (int r = 0; r < 10; r++) begin
            rdy_mode = 2; lat_lo = 1; lat_hi = $urandom_range(1, 8);
            start_run($urandom_range(1, 9));
            for (int k = 0; k < 400 && m_active; k++) begin
                cmd_abort = (r % 2 == 1) && ($urandom_range(0, 19) == 0);
                tick();
            end
            cmd_abort = 1'b0;
            chk("rand_run_ends", m_active, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
